// File: rtl/banco_registradores_n_pkg.sv
// banco_registradores_n_pkg: read-source and stack-op encodings shared by the register bank.
package banco_registradores_n_pkg;

   typedef enum logic [1:0] {
      SEL_REG  = 2'd0,
      SEL_HI   = 2'd1,
      SEL_LO   = 2'd2,
      SEL_ZERO = 2'd3
   } rd_sel_e;

   // Code 2'b11 is deliberately left unnamed: it behaves as no operation.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10
   } stk_op_e;

endpackage

// File: rtl/banco_registradores_n_pilha_ptr.sv
// pilha_ptr: stepping pointer register; a step that would wrap is refused and flagged,
// and a direct load overrides any step without flagging.
module pilha_ptr
   import banco_registradores_n_pkg::*;
#(
   parameter int                 DATA_W  = 32,
   parameter int                 STEP    = 4,
   parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        i_op,
   input  logic              i_ld_en,
   input  logic [DATA_W-1:0] i_ld_data,
   output logic [DATA_W-1:0] o_val,
   output logic              o_wrap
);

   localparam logic [DATA_W-1:0] W_STEP = DATA_W'(STEP);

   logic [DATA_W-1:0] r_val;
   logic              w_push;
   logic              w_pop;
   logic              w_wrap;
   logic [DATA_W-1:0] w_next;

   assign w_push = i_op == OP_PUSH;
   assign w_pop  = i_op == OP_POP;
   // ~W_STEP is the largest value that can still be incremented by STEP without wrapping
   assign w_wrap = !i_ld_en && ((w_push && r_val < W_STEP) || (w_pop && r_val > ~W_STEP));
   assign w_next = i_ld_en ? i_ld_data :
                   w_wrap  ? r_val :
                   w_push  ? r_val - W_STEP :
                   w_pop   ? r_val + W_STEP : r_val;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_val <= RST_VAL;
      else        r_val <= w_next;

   assign o_val  = r_val;
   assign o_wrap = w_wrap;

endmodule

// File: rtl/banco_registradores_n.sv
// banco_registradores_n: register file with HI/LO pair, stack/aux pointers in the top two
// registers, link register below them, write-first read bypass and sticky stack-wrap error.
module banco_registradores_n
   import banco_registradores_n_pkg::*;
#(
   parameter int                 DATA_W = 32,
   parameter int                 NREGS  = 32,
   parameter logic [DATA_W-1:0]  SP_RST = '0,
   parameter int                 AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [1:0]        rd_sel,
   input  logic [AW-1:0]     rd_addr0,
   input  logic [AW-1:0]     rd_addr1,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              hilo_we,
   input  logic [DATA_W-1:0] hi_data,
   input  logic [DATA_W-1:0] lo_data,
   input  logic [1:0]        sp_op,
   input  logic [1:0]        as_op,
   input  logic              cmp_we,
   input  logic              cmp_in,
   input  logic              err_clr,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] sp,
   output logic [DATA_W-1:0] as,
   output logic [DATA_W-1:0] jr,
   output logic              cm,
   output logic              stk_err
);

   localparam logic [AW-1:0] A_SP = AW'(NREGS - 1);
   localparam logic [AW-1:0] A_AS = AW'(NREGS - 2);

   logic [DATA_W-1:0] r_gpr [1:NREGS-3];
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_rd0;
   logic [DATA_W-1:0] r_rd1;
   logic              r_cm;
   logic              r_err;

   logic [DATA_W-1:0] w_file [NREGS];
   logic [DATA_W-1:0] w_sp;
   logic [DATA_W-1:0] w_as;
   logic              w_sp_wrap;
   logic              w_as_wrap;
   logic [DATA_W-1:0] w_hi;
   logic [DATA_W-1:0] w_lo;
   logic [DATA_W-1:0] w_reg0;
   logic [DATA_W-1:0] w_reg1;
   logic [DATA_W-1:0] w_rd0;
   logic [DATA_W-1:0] w_rd1;

   // General registers 1..NREGS-3; address 0 has no storage so its writes vanish
   genvar g;
   generate
      for (g = 1; g <= NREGS - 3; g++) begin : gen_gpr
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)                         r_gpr[g] <= '0;
            else if (wr_en && wr_addr == AW'(g)) r_gpr[g] <= wr_data;
      end
   endgenerate

   pilha_ptr #(.DATA_W(DATA_W), .STEP(DATA_W / 8), .RST_VAL(SP_RST)) u_sp (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_op      (sp_op),
      .i_ld_en   (wr_en && wr_addr == A_SP),
      .i_ld_data (wr_data),
      .o_val     (w_sp),
      .o_wrap    (w_sp_wrap)
   );

   pilha_ptr #(.DATA_W(DATA_W), .STEP(1), .RST_VAL('0)) u_as (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_op      (as_op),
      .i_ld_en   (wr_en && wr_addr == A_AS),
      .i_ld_data (wr_data),
      .o_val     (w_as),
      .o_wrap    (w_as_wrap)
   );

   always_comb begin
      w_file[0] = '0;
      for (int i = 1; i <= NREGS - 3; i++) w_file[i] = r_gpr[i];
      w_file[NREGS-2] = w_as;
      w_file[NREGS-1] = w_sp;
   end

   assign w_reg0 = (rd_addr0 == '0) ? '0 : (wr_en && wr_addr == rd_addr0) ? wr_data : w_file[rd_addr0];
   assign w_reg1 = (rd_addr1 == '0) ? '0 : (wr_en && wr_addr == rd_addr1) ? wr_data : w_file[rd_addr1];
   assign w_hi   = hilo_we ? hi_data : r_hi;
   assign w_lo   = hilo_we ? lo_data : r_lo;
   assign w_rd0  = (rd_sel == SEL_REG) ? w_reg0 :
                   (rd_sel == SEL_HI)  ? w_hi :
                   (rd_sel == SEL_LO)  ? w_lo : '0;
   assign w_rd1  = (rd_sel == SEL_REG) ? w_reg1 : '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_rd0 <= '0;
         r_rd1 <= '0;
         r_cm  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         if (hilo_we) begin
            r_hi <= hi_data;
            r_lo <= lo_data;
         end
         if (rd_en) begin
            r_rd0 <= w_rd0;
            r_rd1 <= w_rd1;
         end
         if (cmp_we) r_cm <= cmp_in;
         // A new wrap wins over a simultaneous clear
         r_err <= w_sp_wrap || w_as_wrap || (r_err && !err_clr);
      end

   assign rd_data0 = r_rd0;
   assign rd_data1 = r_rd1;
   assign sp       = w_sp;
   assign as       = w_as;
   assign jr       = w_file[NREGS-3];
   assign cm       = r_cm;
   assign stk_err  = r_err;

endmodule

// File: tb/tb_banco_registradores_n.sv
// tb_banco_registradores_n: table-driven checks of the 32x32 bank plus hand sequences
// for async reset and a 16-bit, 8-register build.
module tb_banco_registradores_n;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        rd_en, wr_en, hilo_we, cmp_we, cmp_in, err_clr;
   logic [1:0]  rd_sel, sp_op, as_op;
   logic [4:0]  rd_addr0, rd_addr1, wr_addr;
   logic [31:0] wr_data, hi_data, lo_data;
   logic [31:0] rd_data0, rd_data1, sp, as, jr;
   logic        cm, stk_err;

   logic        b_rd_en, b_wr_en, b_hilo_we, b_cmp_we, b_cmp_in, b_err_clr;
   logic [1:0]  b_rd_sel, b_sp_op, b_as_op;
   logic [2:0]  b_rd_addr0, b_rd_addr1, b_wr_addr;
   logic [15:0] b_wr_data, b_hi_data, b_lo_data;
   logic [15:0] b_rd_data0, b_rd_data1, b_sp, b_as, b_jr;
   logic        b_cm, b_stk_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   banco_registradores_n #(.DATA_W(32), .NREGS(32), .SP_RST(32'h100)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_sel(rd_sel),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .hilo_we(hilo_we), .hi_data(hi_data), .lo_data(lo_data),
      .sp_op(sp_op), .as_op(as_op), .cmp_we(cmp_we), .cmp_in(cmp_in), .err_clr(err_clr),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .sp(sp), .as(as), .jr(jr),
      .cm(cm), .stk_err(stk_err)
   );

   banco_registradores_n #(.DATA_W(16), .NREGS(8), .SP_RST(16'h20)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_en(b_rd_en), .rd_sel(b_rd_sel),
      .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .hilo_we(b_hilo_we), .hi_data(b_hi_data), .lo_data(b_lo_data),
      .sp_op(b_sp_op), .as_op(b_as_op), .cmp_we(b_cmp_we), .cmp_in(b_cmp_in), .err_clr(b_err_clr),
      .rd_data0(b_rd_data0), .rd_data1(b_rd_data1), .sp(b_sp), .as(b_as), .jr(b_jr),
      .cm(b_cm), .stk_err(b_stk_err)
   );

   typedef struct {
      logic [31:0] rd_en, sel, a0, a1, we, wa, wd, hw, hi, lo, spo, aso, cwe, cin, clr;
      logic [31:0] e_rd0, e_rd1, e_sp, e_as, e_jr, e_cm, e_err;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rd_en = 0; rd_sel = 0; rd_addr0 = 0; rd_addr1 = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      hilo_we = 0; hi_data = 0; lo_data = 0; sp_op = 0; as_op = 0; cmp_we = 0; cmp_in = 0; err_clr = 0;
      b_rd_en = 0; b_rd_sel = 0; b_rd_addr0 = 0; b_rd_addr1 = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
      b_hilo_we = 0; b_hi_data = 0; b_lo_data = 0; b_sp_op = 0; b_as_op = 0; b_cmp_we = 0; b_cmp_in = 0; b_err_clr = 0;
   endtask

   task automatic chk_main(input string tag, input logic [31:0] r0, r1, s, a, j, c, e);
      chk({tag, ".rd_data0"}, rd_data0, r0);
      chk({tag, ".rd_data1"}, rd_data1, r1);
      chk({tag, ".sp"}, sp, s);
      chk({tag, ".as"}, as, a);
      chk({tag, ".jr"}, jr, j);
      chk({tag, ".cm"}, 32'(cm), c);
      chk({tag, ".stk_err"}, 32'(stk_err), e);
   endtask

   task automatic chk_b_reset(input string tag);
      chk({tag, ".b_rd_data0"}, 32'(b_rd_data0), 0);
      chk({tag, ".b_rd_data1"}, 32'(b_rd_data1), 0);
      chk({tag, ".b_sp"}, 32'(b_sp), 32'h20);
      chk({tag, ".b_as"}, 32'(b_as), 0);
      chk({tag, ".b_jr"}, 32'(b_jr), 0);
      chk({tag, ".b_cm"}, 32'(b_cm), 0);
      chk({tag, ".b_stk_err"}, 32'(b_stk_err), 0);
   endtask

   initial begin
      //            rd sel a0  a1  we wa  wd            hw hi lo spo aso cwe cin clr | rd0           rd1           sp      as            jr       cm err
      vecs[0]  = '{1, 0,  5,  0,  1, 5,  'hDEADBEEF,   0, 0, 0, 0,  0,  0,  0,  0,    'hDEADBEEF,   0,            'h100,  0,            0,       0, 0};
      vecs[1]  = '{1, 0,  0,  5,  1, 0,  'h12345678,   0, 0, 0, 0,  0,  0,  0,  0,    0,            'hDEADBEEF,   'h100,  0,            0,       0, 0};
      vecs[2]  = '{0, 0,  0,  0,  1, 29, 'h1000,       0, 0, 0, 0,  0,  0,  0,  0,    0,            'hDEADBEEF,   'h100,  0,            'h1000,  0, 0};
      vecs[3]  = '{1, 1,  5,  5,  0, 0,  0,            1, 1, 2, 0,  0,  0,  0,  0,    1,            0,            'h100,  0,            'h1000,  0, 0};
      vecs[4]  = '{1, 2,  5,  5,  0, 0,  0,            0, 0, 0, 0,  0,  0,  0,  0,    2,            0,            'h100,  0,            'h1000,  0, 0};
      vecs[5]  = '{1, 3,  5,  5,  0, 0,  0,            0, 0, 0, 0,  0,  0,  0,  0,    0,            0,            'h100,  0,            'h1000,  0, 0};
      vecs[6]  = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 1,  0,  0,  0,  0,    0,            0,            'hFC,   0,            'h1000,  0, 0};
      vecs[7]  = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 1,  0,  0,  0,  0,    0,            0,            'hF8,   0,            'h1000,  0, 0};
      vecs[8]  = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 1,  0,  0,  0,  0,    0,            0,            'hF4,   0,            'h1000,  0, 0};
      vecs[9]  = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 2,  0,  0,  0,  0,    0,            0,            'hF8,   0,            'h1000,  0, 0};
      vecs[10] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  1,  0,  0,  0,    0,            0,            'hF8,   0,            'h1000,  0, 1};
      vecs[11] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 3,  3,  0,  0,  0,    0,            0,            'hF8,   0,            'h1000,  0, 1};
      vecs[12] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  0,  0,  0,  1,    0,            0,            'hF8,   0,            'h1000,  0, 0};
      vecs[13] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  2,  1,  1,  0,    0,            0,            'hF8,   1,            'h1000,  1, 0};
      vecs[14] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  2,  0,  0,  0,    0,            0,            'hF8,   2,            'h1000,  1, 0};
      vecs[15] = '{0, 0,  0,  0,  1, 31, 'h40,         0, 0, 0, 1,  0,  1,  0,  0,    0,            0,            'h40,   2,            'h1000,  0, 0};
      vecs[16] = '{0, 0,  0,  0,  1, 30, 'hFFFFFFFF,   0, 0, 0, 0,  2,  0,  0,  0,    0,            0,            'h40,   'hFFFFFFFF,   'h1000,  0, 0};
      vecs[17] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  2,  0,  0,  0,    0,            0,            'h40,   'hFFFFFFFF,   'h1000,  0, 1};
      vecs[18] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 0,  2,  0,  0,  1,    0,            0,            'h40,   'hFFFFFFFF,   'h1000,  0, 1};
      vecs[19] = '{1, 0,  31, 30, 0, 0,  0,            0, 0, 0, 0,  0,  0,  0,  1,    'h40,         'hFFFFFFFF,   'h40,   'hFFFFFFFF,   'h1000,  0, 0};
      vecs[20] = '{1, 0,  31, 30, 1, 31, 'h80,         0, 0, 0, 0,  0,  0,  0,  0,    'h80,         'hFFFFFFFF,   'h80,   'hFFFFFFFF,   'h1000,  0, 0};
      vecs[21] = '{0, 0,  0,  0,  1, 31, 'h4,          0, 0, 0, 0,  0,  0,  0,  0,    'h80,         'hFFFFFFFF,   'h4,    'hFFFFFFFF,   'h1000,  0, 0};
      vecs[22] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 1,  0,  0,  0,  0,    'h80,         'hFFFFFFFF,   0,      'hFFFFFFFF,   'h1000,  0, 0};
      vecs[23] = '{0, 0,  0,  0,  0, 0,  0,            0, 0, 0, 1,  0,  0,  0,  0,    'h80,         'hFFFFFFFF,   0,      'hFFFFFFFF,   'h1000,  0, 1};

      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk_main("reset", 0, 0, 32'h100, 0, 0, 0, 0);
      chk_b_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rd_en = vecs[i].rd_en[0]; rd_sel = vecs[i].sel[1:0];
         rd_addr0 = vecs[i].a0[4:0]; rd_addr1 = vecs[i].a1[4:0];
         wr_en = vecs[i].we[0]; wr_addr = vecs[i].wa[4:0]; wr_data = vecs[i].wd;
         hilo_we = vecs[i].hw[0]; hi_data = vecs[i].hi; lo_data = vecs[i].lo;
         sp_op = vecs[i].spo[1:0]; as_op = vecs[i].aso[1:0];
         cmp_we = vecs[i].cwe[0]; cmp_in = vecs[i].cin[0]; err_clr = vecs[i].clr[0];
         @(posedge clk);
         #1;
         chk_main($sformatf("v%0d", i), vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_sp,
                  vecs[i].e_as, vecs[i].e_jr, vecs[i].e_cm, vecs[i].e_err);
      end

      // Build some state in both banks before an asynchronous reset between edges
      @(negedge clk);
      idle_inputs();
      wr_en = 1; wr_addr = 7; wr_data = 32'h77; cmp_we = 1; cmp_in = 1;
      b_wr_en = 1; b_wr_addr = 5; b_wr_data = 16'hABCD; b_rd_en = 1; b_rd_addr0 = 5;
      b_sp_op = 2'b01; b_as_op = 2'b01;
      @(posedge clk);
      #1;
      chk("b.rd_data0_bypass", 32'(b_rd_data0), 32'hABCD);
      chk("b.jr", 32'(b_jr), 32'hABCD);
      chk("b.sp_push2", 32'(b_sp), 32'h1E);
      chk("b.as_wrap", 32'(b_as), 0);
      chk("b.stk_err", 32'(b_stk_err), 1);
      chk("pre.cm", 32'(cm), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_main("async", 0, 0, 32'h100, 0, 0, 0, 0);
      chk_b_reset("async");

      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      rd_en = 1; rd_addr0 = 5; rd_addr1 = 29; wr_en = 1; wr_addr = 5; wr_data = 32'hCAFE;
      @(posedge clk);
      #1;
      chk_main("post", 32'hCAFE, 0, 32'h100, 0, 0, 0, 0);

      @(negedge clk);
      idle_inputs();
      rd_en = 1; rd_addr0 = 7; rd_addr1 = 5;
      @(posedge clk);
      #1;
      chk("post.r7_cleared", rd_data0, 0);
      chk("post.r5_kept", rd_data1, 32'hCAFE);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
